fir_seq_ctrl: RTL
=================

Name: fir_seq_ctrl

Overview:
Scheduler for the stereo FIR filter bank (B1/B2/B3-style ROM-coefficient filters). On each new audio sample it drives the filters' `sequencing` strobe for a fixed window and walks the circular sample-queue read address in lock-step. It then pulses a capture strobe in the one cycle where the filters' `lft_out`/`rght_out` hold the finished sums. It sits between the circular queue and all filter instances, which share its `sequencing` output.

Parameters:
- NUM_TAPS, 1021: coefficients per filter.
- SEQ_LEN, NUM_TAPS+1: cycles `sequencing` stays high; the +1 covers the one-cycle coefficient ROM read latency.
- QUEUE_DEPTH, 1536: entries in the circular sample queue.
- QA_W, 11: queue address width; must satisfy 2^QA_W >= QUEUE_DEPTH.
- CNT_W, 11: window counter width; must satisfy 2^CNT_W > SEQ_LEN.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- smpl_rdy  in  1  one-cycle pulse: new L/R sample written to queue
- q_full  in  1  queue holds >= NUM_TAPS valid samples
- q_old_ptr  in  QA_W  address of oldest sample in queue
- clr_ovr  in  1  clears sticky overrun flag
- sequencing  out  1  filter enable; shared by all filter instances
- q_rd_addr  out  QA_W  queue read address
- filt_done  out  1  one-cycle capture strobe for filter outputs
- busy  out  1  high in RUN or DONE
- overrun  out  1  sticky: a sample was dropped

Behaviour:
- Reset values: `sequencing`=0, `q_rd_addr`=0, `filt_done`=0, `busy`=0, `overrun`=0, pending=0, counter=0, state=IDLE.
- All outputs are registered. Reset is checked first every edge and wins over every other input.
- States:
  - IDLE: `smpl_rdy`&`q_full` -> RUN. `smpl_rdy`&!`q_full` is ignored (queue still filling; not an overrun).
  - RUN: `sequencing`=1, counter increments. When counter==SEQ_LEN-1 -> DONE.
  - DONE: `sequencing`=0, `filt_done`=1 for exactly one cycle. Then pending ? RUN : IDLE.
- Latency: `smpl_rdy` sampled high at edge T (IDLE, `q_full`=1).
  - `sequencing` is high during cycles T+1 .. T+SEQ_LEN.
  - `filt_done` is high in cycle T+SEQ_LEN+1.
  - Back-to-back from DONE: `sequencing` rises in the cycle right after `filt_done`.
- Minimum `sequencing` low gap between windows is 1 cycle, which the filters' rising-edge accumulator clear requires.
- Address:
  - On IDLE/DONE->RUN, `q_rd_addr` loads `q_old_ptr`, sampled that same edge.
  - In RUN it increments once per cycle.
  - QUEUE_DEPTH-1 wraps to 0; never reaches QUEUE_DEPTH.
  - It holds its value in IDLE/DONE.
- Pending (1-deep):
  - `smpl_rdy` while `busy` sets pending.
  - `smpl_rdy` while `busy` and pending already set sets `overrun`; the sample is dropped.
  - Pending clears on the DONE->RUN transition.
  - `smpl_rdy` in DONE with pending=0 sets pending and proceeds normally.
- `overrun`: set has priority over `clr_ovr` in the same cycle; otherwise `clr_ovr` clears it.
- `q_full` is sampled only at window start; deassertion during RUN does not abort.
- Reset mid-RUN: next cycle `sequencing`=0, no `filt_done`, pending lost.
- Counter is CNT_W bits and never exceeds SEQ_LEN-1.

Decomposition:
- Package `fir_seq_pkg`:
  - state enum {IDLE, RUN, DONE} (2 bits)
  - default NUM_TAPS / QUEUE_DEPTH constants
  - function computing SEQ_LEN
- One sub-module, `wrap_addr_cnt`:
  - Inputs: load, load value, inc.
  - Output: address with modulo-QUEUE_DEPTH wrap.
  - Used for `q_rd_addr`; reusable by the queue writer.

Test Plan:
All scenarios run with NUM_TAPS=4 (SEQ_LEN=5), QUEUE_DEPTH=8, QA_W=3.
- Single window:
  - Stimulus: `q_full`=1, `q_old_ptr`=2, `smpl_rdy` at edge 10.
  - Response: `sequencing` high cycles 11-15; `q_rd_addr` 2,3,4,5,6 during them; `filt_done` only in cycle 16; `busy` high cycles 11-16; back to IDLE.
- Wrap:
  - Stimulus: `q_old_ptr`=6.
  - Response: `q_rd_addr` sequence 6,7,0,1,2; never 8.
- Not full:
  - Stimulus: `q_full`=0 with `smpl_rdy` pulses.
  - Response: `sequencing`, `filt_done` and `overrun` all stay 0.
- Pending:
  - Stimulus: second `smpl_rdy` at cycle 13 during RUN.
  - Response: `filt_done` at 16; `sequencing` high again cycles 17-21; `filt_done` at 22; `overrun`=0.
- Overrun:
  - Stimulus: `smpl_rdy` at 12 and 14 during RUN.
  - Response: `overrun`=1 from cycle 15, persists after both windows. `clr_ovr` then clears it. `clr_ovr` coincident with a new overrun event leaves it 1.
- Reset mid-run:
  - Stimulus: `rst` at cycle 13.
  - Response: cycle 14 shows all outputs 0, including `sequencing` and `q_rd_addr`; no `filt_done`. A fresh `smpl_rdy` afterwards gives nominal timing.

Source files
------------

// File: rtl/fir_seq_pkg.sv
// -----------------------------------------------------------------------------
// fir_seq_pkg
// Shared types and defaults for the FIR filter-bank scheduler.
//   seq_state_t   : scheduler FSM state (IDLE / RUN / DONE), 2 bits
//   DEF_NUM_TAPS  : default coefficient count per filter
//   DEF_QUEUE_DEPTH / DEF_QA_W : default circular sample queue geometry
//   calc_seq_len  : length of the sequencing window for a given tap count
// -----------------------------------------------------------------------------
package fir_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

    localparam int DEF_NUM_TAPS    = 1021;
    localparam int DEF_QUEUE_DEPTH = 1536;
    localparam int DEF_QA_W        = 11;
    localparam int DEF_CNT_W       = 11;

    // One extra cycle beyond the tap count: the coefficient ROM has a
    // single cycle of read latency, so the last product lands one cycle late.
    function automatic int calc_seq_len(input int num_taps);
        return num_taps + 1;
    endfunction

endpackage

// File: rtl/wrap_addr_cnt.sv
// -----------------------------------------------------------------------------
// wrap_addr_cnt
// Address counter for a circular buffer whose depth need not be a power of
// two. Load has priority over increment; increment wraps DEPTH-1 -> 0 so the
// address never reaches DEPTH.
// Ports:
//   clk, rst   : clock, synchronous active-high reset (address -> 0)
//   load       : load load_val this edge
//   load_val   : value to load (must be < DEPTH)
//   inc        : advance by one, modulo DEPTH
//   addr       : current address (registered)
// -----------------------------------------------------------------------------
module wrap_addr_cnt
    import fir_seq_pkg::*;
#(
    parameter int DEPTH = DEF_QUEUE_DEPTH,
    parameter int AW    = DEF_QA_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [AW-1:0] load_val,
    input  logic          inc,
    output logic [AW-1:0] addr
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    logic [AW-1:0] addr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= '0;
        end else if (load) begin
            addr_q <= load_val;
        end else if (inc) begin
            addr_q <= (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;
        end
    end

    assign addr = addr_q;

endmodule

// File: rtl/fir_seq_ctrl.sv
// -----------------------------------------------------------------------------
// fir_seq_ctrl
// Scheduler for the stereo FIR filter bank. Each accepted audio sample opens
// a window of SEQ_LEN cycles during which `sequencing` is high and the queue
// read address walks forward from the oldest sample. The cycle after the
// window, `filt_done` strobes once so the filter sums can be captured.
//
// Sample handshake: smpl_rdy is a one-cycle pulse with no back-pressure.
// While idle it is accepted only if q_full is high (otherwise the queue is
// still priming and the pulse is ignored). While busy it is held in a 1-deep
// pending slot; a pulse arriving with the slot already occupied is dropped and
// raises the sticky overrun flag.
//
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   smpl_rdy    : new L/R sample written to the queue (1-cycle pulse)
//   q_full      : queue holds at least NUM_TAPS samples
//   q_old_ptr   : address of oldest queue entry, loaded at window start
//   clr_ovr     : clear sticky overrun (a same-cycle new overrun wins)
//   sequencing  : filter enable, shared by all filter instances
//   q_rd_addr   : queue read address
//   filt_done   : 1-cycle capture strobe for filter outputs
//   busy        : high while in RUN or DONE
//   overrun     : sticky, a sample was dropped
// -----------------------------------------------------------------------------
module fir_seq_ctrl
    import fir_seq_pkg::*;
#(
    parameter int NUM_TAPS    = DEF_NUM_TAPS,
    parameter int SEQ_LEN     = calc_seq_len(NUM_TAPS),
    parameter int QUEUE_DEPTH = DEF_QUEUE_DEPTH,
    parameter int QA_W        = DEF_QA_W,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            smpl_rdy,
    input  logic            q_full,
    input  logic [QA_W-1:0] q_old_ptr,
    input  logic            clr_ovr,
    output logic            sequencing,
    output logic [QA_W-1:0] q_rd_addr,
    output logic            filt_done,
    output logic            busy,
    output logic            overrun
);

    // Parameter sanity, caught at elaboration.
    generate
        if ((2 ** QA_W) < QUEUE_DEPTH) begin : g_bad_qa_w
            $error("fir_seq_ctrl: QA_W too narrow for QUEUE_DEPTH");
        end
        if ((2 ** CNT_W) <= SEQ_LEN) begin : g_bad_cnt_w
            $error("fir_seq_ctrl: CNT_W too narrow for SEQ_LEN");
        end
    endgenerate

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SEQ_LEN - 1);

    seq_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pending_q, pending_d;
    logic             overrun_q, overrun_d;
    logic             ovr_set;
    logic             addr_load;
    logic             addr_inc;

    logic             seq_q;
    logic             done_q;
    logic             busy_q;

    // ------------------------------------------------------------------
    // Next-state, counter, pending slot and address control.
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pending_d = pending_q;
        ovr_set   = 1'b0;
        addr_load = 1'b0;
        addr_inc  = 1'b0;

        unique case (state_q)
            IDLE: begin
                // q_full is only consulted here, at window start; a pulse
                // while the queue is still filling is simply not a sample.
                if (smpl_rdy && q_full) begin
                    state_d   = RUN;
                    cnt_d     = '0;
                    addr_load = 1'b1;
                end
            end

            RUN: begin
                addr_inc = 1'b1;
                if (smpl_rdy) begin
                    if (pending_q) begin
                        ovr_set = 1'b1;
                    end else begin
                        pending_d = 1'b1;
                    end
                end
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            DONE: begin
                cnt_d = '0;
                // A pulse landing in DONE counts as a pending sample, so the
                // next window starts right after filt_done either way. If the
                // slot was already occupied, the new pulse is the one dropped.
                if (smpl_rdy && pending_q) begin
                    ovr_set = 1'b1;
                end
                if (pending_q || smpl_rdy) begin
                    state_d   = RUN;
                    pending_d = 1'b0;
                    addr_load = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d   = IDLE;
                cnt_d     = '0;
                pending_d = 1'b0;
            end
        endcase

        // A fresh overrun beats a same-cycle clear so no drop goes unseen.
        if (ovr_set) begin
            overrun_d = 1'b1;
        end else if (clr_ovr) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end
    end

    // ------------------------------------------------------------------
    // State register. Outputs are decoded from the next state and
    // registered, so they line up with the state they describe.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
            seq_q     <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            seq_q     <= (state_d == RUN);
            done_q    <= (state_d == DONE);
            busy_q    <= (state_d != IDLE);
        end
    end

    // ------------------------------------------------------------------
    // Queue read address: loads the oldest-sample pointer at window start
    // and walks forward once per RUN cycle with modulo-depth wrap.
    // ------------------------------------------------------------------
    wrap_addr_cnt #(
        .DEPTH (QUEUE_DEPTH),
        .AW    (QA_W)
    ) u_rd_addr (
        .clk      (clk),
        .rst      (rst),
        .load     (addr_load),
        .load_val (q_old_ptr),
        .inc      (addr_inc),
        .addr     (q_rd_addr)
    );

    assign sequencing = seq_q;
    assign filt_done  = done_q;
    assign busy       = busy_q;
    assign overrun    = overrun_q;

endmodule
